instr_sequencer: RTL

Parametrised successor to the single-cycle instruction decoder. It owns the program counter and decodes each 16-bit instruction into datapath controls (register addresses, mux selects, ALU op, write enable). It adds an instruction-valid stall, a RUN/HALTED state machine with resume, and condition evaluation on real register data rather than on register indices. It also adds call/return through a hardware return stack. It sits between instruction memory and the register file/ALU datapath.

---
 rtl/instr_seq_pkg.sv | 38 +++
 rtl/instr_seq_if.sv | 35 +++
 rtl/seq_return_stack.sv | 53 +++++
 rtl/instr_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared constants for the instruction sequencer: opcodes, ALU codes and run state.
package instr_seq_pkg;

  localparam logic [3:0] OP_SETC    = 4'h0;
  localparam logic [3:0] OP_LDX     = 4'h1;
  localparam logic [3:0] OP_COPY    = 4'h2;
  localparam logic [3:0] OP_CCOPY   = 4'h3;
  localparam logic [3:0] OP_ADD     = 4'h4;
  localparam logic [3:0] OP_NEG     = 4'h5;
  localparam logic [3:0] OP_AND     = 4'h6;
  localparam logic [3:0] OP_OR      = 4'h7;
  localparam logic [3:0] OP_SHL     = 4'h8;
  localparam logic [3:0] OP_SHR     = 4'h9;
  localparam logic [3:0] OP_EQ      = 4'hA;
  localparam logic [3:0] OP_GT      = 4'hB;
  localparam logic [3:0] OP_CALLRET = 4'hC;
  localparam logic [3:0] OP_JMP     = 4'hD;
  localparam logic [3:0] OP_HALT    = 4'hE;
  localparam logic [3:0] OP_CHALT   = 4'hF;

  // Code 0 is the idle ALU op used by every non-ALU opcode.
  localparam logic [3:0] ALU_NONE  = 4'd0;
  localparam logic [3:0] ALU_PASSA = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_NEG   = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_SHL   = 4'd6;
  localparam logic [3:0] ALU_SHR   = 4'd7;
  localparam logic [3:0] ALU_EQ    = 4'd8;
  localparam logic [3:0] ALU_GT    = 4'd9;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HALTED  = 1'b1
  } state_e;

endpackage

// File: rtl/instr_seq_if.sv
// Sequencer bus: instruction and datapath status in, PC and decoded controls out.
interface instr_seq_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [15:0]       instruction;
  logic              instr_valid;
  logic [DATA_W-1:0] cond_data;
  logic [DATA_W-1:0] ext_data;
  logic              resume;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        dest_addr;
  logic [3:0]        b_addr;
  logic [3:0]        a_addr;
  logic              write_src_sel;
  logic              mux_b_sel;
  logic              mux_a_sel;
  logic [3:0]        alu_op;
  logic              write_en;
  logic [DATA_W-1:0] sel_data;
  logic              halted;
  logic              stack_err;

  modport master (
    input  instruction, instr_valid, cond_data, ext_data, resume,
    output pc, dest_addr, b_addr, a_addr, write_src_sel, mux_b_sel, mux_a_sel, alu_op,
           write_en, sel_data, halted, stack_err
  );

  modport slave (
    output instruction, instr_valid, cond_data, ext_data, resume,
    input  pc, dest_addr, b_addr, a_addr, write_src_sel, mux_b_sel, mux_a_sel, alu_op,
           write_en, sel_data, halted, stack_err
  );
endinterface

// File: rtl/seq_return_stack.sv
// Return-address stack (LIFO) for CALL/RET; push when full and pop when empty are ignored.
module seq_return_stack #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] top_o
);
  localparam int unsigned PtrW = $clog2(STACK_DEPTH);
  localparam logic [PtrW:0]   SpOne  = 1;
  localparam logic [PtrW:0]   SpFull = STACK_DEPTH[PtrW:0];
  localparam logic [PtrW-1:0] IdxOne = 1;

  logic [PtrW:0]     sp_q, sp_d;
  logic [PtrW-1:0]   wr_idx, rd_idx;
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];

  // sp counts entries, so the next free slot is its low bits and the top sits one below.
  assign wr_idx  = sp_q[PtrW-1:0];
  assign rd_idx  = wr_idx - IdxOne;
  assign full_o  = (sp_q == SpFull);
  assign empty_o = (sp_q == '0);
  assign top_o   = mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + SpOne;
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SpOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end
endmodule

// File: rtl/instr_sequencer.sv
// Program counter, RUN/HALTED control and 16-bit instruction decode.
// Define INSTR_SEQ_STACK_EN to enable CALL/RET with a hardware return stack.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  instr_seq_if.master  bus_io
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, target;
  logic [3:0]        opcode;
  logic              cond_nz;
  logic              wsel, bsel, writes;
  logic [3:0]        alu;
  logic [DATA_W-1:0] sel;

  assign opcode  = bus_io.instruction[15:12];
  assign cond_nz = |bus_io.cond_data;
  assign pc_inc  = pc_q + 1'b1;
  assign target  = bus_io.instruction[ADDR_W-1:0];

`ifdef INSTR_SEQ_STACK_EN
  logic              push, pop, full, empty, err_q, err_d;
  logic [ADDR_W-1:0] top;

  seq_return_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .ADDR_W      (ADDR_W)
  ) u_stack (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_inc),
    .full_o      (full),
    .empty_o     (empty),
    .top_o       (top)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef INSTR_SEQ_STACK_EN
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
`endif
    unique case (state_q)
      ST_RUN: begin
        if (bus_io.instr_valid) begin
          case (opcode)
            OP_JMP: pc_d = target;
`ifdef INSTR_SEQ_STACK_EN
            OP_CALLRET: begin
              // Stack faults halt with pc parked on the offending instruction.
              if (!bus_io.instruction[11]) begin
                if (full) begin
                  err_d   = 1'b1;
                  state_d = ST_HALTED;
                end else begin
                  push = 1'b1;
                  pc_d = target;
                end
              end else begin
                if (empty) begin
                  err_d   = 1'b1;
                  state_d = ST_HALTED;
                end else begin
                  pop  = 1'b1;
                  pc_d = top;
                end
              end
            end
`endif
            OP_HALT: state_d = ST_HALTED;
            OP_CHALT: begin
              if (cond_nz) begin
                state_d = ST_HALTED;
              end else begin
                pc_d = pc_inc;
              end
            end
            default: pc_d = pc_inc;
          endcase
        end
      end
      ST_HALTED: begin
        if (bus_io.resume) begin
          state_d = ST_RUN;
          pc_d    = pc_inc;
        end
      end
    endcase
  end

  always_comb begin
    wsel   = 1'b0;
    bsel   = 1'b0;
    alu    = ALU_NONE;
    sel    = '0;
    writes = 1'b0;
    case (opcode)
      OP_SETC: begin
        wsel   = 1'b1;
        sel    = DATA_W'(bus_io.instruction[7:0]);
        writes = 1'b1;
      end
      OP_LDX: begin
        wsel   = 1'b1;
        sel    = bus_io.ext_data;
        writes = 1'b1;
      end
      OP_COPY:  begin alu = ALU_PASSA; writes = 1'b1;    end
      OP_CCOPY: begin alu = ALU_PASSA; writes = cond_nz; end
      OP_ADD:   begin alu = ALU_ADD;   writes = 1'b1;    end
      OP_NEG:   begin alu = ALU_NEG;   writes = 1'b1;    end
      OP_AND:   begin alu = ALU_AND;   writes = 1'b1;    end
      OP_OR:    begin alu = ALU_OR;    writes = 1'b1;    end
      OP_SHL:   begin alu = ALU_SHL;   writes = 1'b1; bsel = 1'b1; end
      OP_SHR:   begin alu = ALU_SHR;   writes = 1'b1; bsel = 1'b1; end
      OP_EQ:    begin alu = ALU_EQ;    writes = 1'b1;    end
      OP_GT:    begin alu = ALU_GT;    writes = 1'b1;    end
      default: ;
    endcase
  end

  assign bus_io.pc            = pc_q;
  assign bus_io.dest_addr     = bus_io.instruction[11:8];
  assign bus_io.b_addr        = bus_io.instruction[7:4];
  assign bus_io.a_addr        = bus_io.instruction[3:0];
  assign bus_io.write_src_sel = wsel;
  assign bus_io.mux_b_sel     = bsel;
  assign bus_io.mux_a_sel     = 1'b0;
  assign bus_io.alu_op        = alu;
  assign bus_io.sel_data      = sel;
  assign bus_io.write_en      = (state_q == ST_RUN) && bus_io.instr_valid && writes;
  assign bus_io.halted        = (state_q == ST_HALTED);
`ifdef INSTR_SEQ_STACK_EN
  assign bus_io.stack_err     = err_q;
`else
  assign bus_io.stack_err     = 1'b0;
`endif
endmodule
